// File: rtl/switch_scan_debouncer_pkg.sv
// Shared definitions for the time-multiplexed switch debouncer.
//   scan_state_t  : four-phase visit state (SAMPLE, COMPARE, COMMIT, ADVANCE)
//   VISIT_CYCLES  : cycles spent on one switch per visit
//   clog2_w       : width helper, never returns less than 1
//   next_state    : successor of a visit phase (wraps ADVANCE -> SAMPLE)
// Optional feature macro used by the top: SW_SCAN_LED_TOGGLE_EN.
package sw_scan_pkg;

  typedef enum logic [1:0] {
    SAMPLE  = 2'd0,
    COMPARE = 2'd1,
    COMMIT  = 2'd2,
    ADVANCE = 2'd3
  } scan_state_t;

  localparam int VISIT_CYCLES = 4;

  // Bits needed to index/hold 'value' distinct codes; a one-entry range still
  // needs a 1-bit signal.
  function automatic int clog2_w(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << width) < value) width = width + 1;
    end
    return width;
  endfunction

  // Each phase lasts one cycle, so the successor is simply the next code.
  function automatic scan_state_t next_state(input scan_state_t s);
    logic [1:0] n;
    n = 2'((int'(s) + 1) % VISIT_CYCLES);
    return scan_state_t'(n);
  endfunction

endpackage

// File: rtl/switch_scan_debouncer_if.sv
// Bundle of switch-side and user-side signals of the scan debouncer.
//   i_Switch   : raw board switch pins
//   o_Switch   : debounced levels
//   o_Press    : one-cycle pulse on committed 0->1
//   o_Release  : one-cycle pulse on committed 1->0
//   o_LED      : per-switch toggle state
//   o_Scan_Idx : switch currently being serviced
// Modports: slave = the debouncer, master = the board/user side.
interface switch_scan_debouncer_if #(
  parameter int NUM_SW = 4
);
  import sw_scan_pkg::*;

  localparam int IDX_W = clog2_w(NUM_SW);

  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Switch;
  logic [NUM_SW-1:0] o_Press;
  logic [NUM_SW-1:0] o_Release;
  logic [NUM_SW-1:0] o_LED;
  logic [IDX_W-1:0]  o_Scan_Idx;

  modport slave (
    input  i_Switch,
    output o_Switch, o_Press, o_Release, o_LED, o_Scan_Idx
  );

  modport master (
    output i_Switch,
    input  o_Switch, o_Press, o_Release, o_LED, o_Scan_Idx
  );

endinterface

// File: rtl/switch_scan_debouncer_sync.sv
// sw_sync_2ff: WIDTH-bit two-flop synchronizer for asynchronous switch pins.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous inputs
//   q     : synchronized outputs (two cycles of delay)
module sw_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_scan_debouncer.sv
// switch_scan_debouncer: one scan FSM and one shared increment/compare path
// debounce NUM_SW switches in turn. Each switch is visited for four cycles
// (SAMPLE, COMPARE, COMMIT, ADVANCE); a new level is committed once
// STABLE_VISITS consecutive visits have seen it.
//   i_Clk   : system clock
//   i_Rst_L : asynchronous active-low reset
//   bus     : switch_scan_debouncer_if.slave (raw pins in, debounced
//             levels, press/release pulses, LED toggles, scan index out)
// Optional feature: define SW_SCAN_LED_TOGGLE_EN to build the per-switch
// LED toggle registers; otherwise o_LED is tied low.
module switch_scan_debouncer
  import sw_scan_pkg::*;
#(
  parameter int NUM_SW        = 4,
  parameter int STABLE_VISITS = 15625
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  switch_scan_debouncer_if.slave  bus
);

  localparam int IDX_W = clog2_w(NUM_SW);
  localparam int CNT_W = clog2_w(STABLE_VISITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SW - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_VISITS);

  logic [NUM_SW-1:0] sw_sync;
  scan_state_t       state;
  logic [IDX_W-1:0]  scan_idx;
  logic              sample;
  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] press_q;
  logic [NUM_SW-1:0] release_q;
  logic [CNT_W-1:0]  count [NUM_SW];

  sw_sync_2ff #(
    .WIDTH (NUM_SW)
  ) u_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .d     (bus.i_Switch),
    .q     (sw_sync)
  );

  // Scan FSM with the shared datapath. Only the switch at scan_idx is touched
  // in any cycle, so one incrementer and one comparator serve all switches.
  // Pulses default low every cycle and are raised only by a committing COMMIT,
  // which makes them exactly one cycle wide and mutually exclusive.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= SAMPLE;
      scan_idx  <= '0;
      sample    <= 1'b0;
      stable    <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        count[i] <= '0;
      end
    end else begin
      state     <= next_state(state);
      press_q   <= '0;
      release_q <= '0;
      case (state)
        SAMPLE: begin
          sample <= sw_sync[scan_idx];
        end
        COMPARE: begin
          // Any visit that sees the committed level breaks the run.
          if (sample == stable[scan_idx]) begin
            count[scan_idx] <= '0;
          end else begin
            count[scan_idx] <= count[scan_idx] + CNT_W'(1);
          end
        end
        COMMIT: begin
          // Clearing here keeps the count from ever passing STABLE_VISITS.
          if (count[scan_idx] == CNT_DONE) begin
            stable[scan_idx]    <= sample;
            count[scan_idx]     <= '0;
            press_q[scan_idx]   <= sample;
            release_q[scan_idx] <= ~sample;
          end
        end
        ADVANCE: begin
          scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SW_SCAN_LED_TOGGLE_EN
  logic [NUM_SW-1:0] led_q;

  // Toggle on the registered release pulse, so the LED flips one cycle after
  // o_Release is seen.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      led_q <= '0;
    end else begin
      led_q <= led_q ^ release_q;
    end
  end

  assign bus.o_LED = led_q;
`else
  assign bus.o_LED = '0;
`endif

  assign bus.o_Switch   = stable;
  assign bus.o_Press    = press_q;
  assign bus.o_Release  = release_q;
  assign bus.o_Scan_Idx = scan_idx;

endmodule

// File: tb/tb_switch_scan_debouncer.sv
// Directed testbench for switch_scan_debouncer with NUM_SW=4, STABLE_VISITS=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// LED expectations follow SW_SCAN_LED_TOGGLE_EN.
module tb_switch_scan_debouncer;
  import sw_scan_pkg::*;

  localparam int NUM_SW        = 4;
  localparam int STABLE_VISITS = 3;
  localparam int SCAN_CYCLES   = VISIT_CYCLES * NUM_SW;
  localparam int WORST_LAT     = 2 + SCAN_CYCLES * STABLE_VISITS + SCAN_CYCLES;
  localparam int SETTLE        = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_scan_debouncer_if #(.NUM_SW(NUM_SW)) sw_bus ();

  switch_scan_debouncer #(
    .NUM_SW        (NUM_SW),
    .STABLE_VISITS (STABLE_VISITS)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (sw_bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance to the first cycle in which the scan index equals 'target'.
  task automatic wait_idx(input logic [1:0] target);
    int guard;
    guard = 0;
    while (sw_bus.o_Scan_Idx !== target && guard < 40) begin
      tick();
      guard++;
    end
    vectors++;
    if (sw_bus.o_Scan_Idx !== target) begin
      miscompares++;
      $display("[TB] FAIL wait_idx: index %0d never reached, stuck at %0d", target, sw_bus.o_Scan_Idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_bus.i_Switch = 4'b1111;
    repeat (5) tick();
    vectors++;
    if (sw_bus.o_Switch !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_switch: got %b expected 0000", sw_bus.o_Switch);
    end
    vectors++;
    if ((sw_bus.o_Press | sw_bus.o_Release) !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses: got press %b release %b expected 0000", sw_bus.o_Press, sw_bus.o_Release);
    end
    vectors++;
    if (sw_bus.o_LED !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_led: got %b expected 0000", sw_bus.o_LED);
    end
    vectors++;
    if (sw_bus.o_Scan_Idx !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idx: got %0d expected 0", sw_bus.o_Scan_Idx);
    end
    sw_bus.i_Switch = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    // Four cycles per switch, starting with index 0 in the release cycle.
    for (int k = 0; k < 20; k++) begin
      logic [1:0] exp_idx;
      exp_idx = 2'((k / 4) % 4);
      vectors++;
      if (sw_bus.o_Scan_Idx !== exp_idx) begin
        miscompares++;
        $display("[TB] FAIL scan_idx_seq[%0d]: got %0d expected %0d", k, sw_bus.o_Scan_Idx, exp_idx);
      end
      tick();
    end
  endtask

  task automatic test_clean_press();
    int press_cnt, other_cnt, rise_at, press_at;
    press_cnt = 0; other_cnt = 0; rise_at = -1; press_at = -1;
    sw_bus.i_Switch[2] = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (sw_bus.o_Press[2]) begin
        press_cnt++;
        if (press_at < 0) press_at = k;
      end
      if (((sw_bus.o_Press & 4'b1011) | sw_bus.o_Release) != 4'b0000) other_cnt++;
      if (rise_at < 0 && sw_bus.o_Switch[2]) rise_at = k;
    end
    vectors++;
    if (press_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL press2_count: got %0d pulse cycles expected 1", press_cnt);
    end
    vectors++;
    if (other_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL press2_others: got %0d stray pulse cycles expected 0", other_cnt);
    end
    vectors++;
    if (sw_bus.o_Switch !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL press2_level: got %b expected 0100", sw_bus.o_Switch);
    end
    vectors++;
    if (rise_at < 2 + SCAN_CYCLES * (STABLE_VISITS - 1) || rise_at > WORST_LAT) begin
      miscompares++;
      $display("[TB] FAIL press2_latency: got %0d cycles expected %0d..%0d", rise_at,
               2 + SCAN_CYCLES * (STABLE_VISITS - 1), WORST_LAT);
    end
    vectors++;
    if (press_at !== rise_at) begin
      miscompares++;
      $display("[TB] FAIL press2_align: pulse at %0d level at %0d expected equal", press_at, rise_at);
    end
  endtask

  task automatic test_bounce();
    int bad_pulses, press_cnt, other_cnt;
    logic lvl;
    bad_pulses = 0; press_cnt = 0; other_cnt = 0; lvl = 1'b0;
    // A half period equal to one scan makes consecutive visits of switch 1
    // always see opposite levels, so every run is broken after one visit.
    for (int k = 0; k < 13 * SCAN_CYCLES; k++) begin
      if (k % SCAN_CYCLES == 0) begin
        lvl = ~lvl;
        sw_bus.i_Switch[1] = lvl;
      end
      tick();
      if ((sw_bus.o_Press | sw_bus.o_Release) != 4'b0000) bad_pulses++;
    end
    sw_bus.i_Switch[1] = 1'b1;
    for (int k = 1; k <= SETTLE; k++) begin
      tick();
      if (sw_bus.o_Press[1]) press_cnt++;
      if (((sw_bus.o_Press & 4'b1101) | sw_bus.o_Release) != 4'b0000) other_cnt++;
    end
    vectors++;
    if (bad_pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_quiet: got %0d pulse cycles while bouncing expected 0", bad_pulses);
    end
    vectors++;
    if (press_cnt !== 1 || other_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL bounce_press: got %0d press1 / %0d other expected 1 / 0", press_cnt, other_cnt);
    end
    vectors++;
    if (sw_bus.o_Switch !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL bounce_level: got %b expected 0110", sw_bus.o_Switch);
    end
  endtask

  task automatic test_release_led();
    logic led_exp;
    logic led_final;
    int press_cnt, rel_cnt, led_bad;
    led_exp = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      press_cnt = 0; rel_cnt = 0; led_bad = 0;
      sw_bus.i_Switch[0] = 1'b1;
      for (int k = 1; k <= SETTLE; k++) begin
        tick();
        if (sw_bus.o_Press[0]) press_cnt++;
        if (sw_bus.o_LED[0] !== led_exp) led_bad++;
      end
      sw_bus.i_Switch[0] = 1'b0;
      for (int k = 1; k <= SETTLE; k++) begin
        tick();
        if (sw_bus.o_LED[0] !== led_exp) led_bad++;
        if (sw_bus.o_Release[0]) begin
          rel_cnt++;
`ifdef SW_SCAN_LED_TOGGLE_EN
          led_exp = ~led_exp;
`endif
        end
      end
`ifdef SW_SCAN_LED_TOGGLE_EN
      led_final = (rep == 0) ? 1'b1 : 1'b0;
`else
      led_final = 1'b0;
`endif
      vectors++;
      if (press_cnt !== 1 || rel_cnt !== 1) begin
        miscompares++;
        $display("[TB] FAIL sw0_pulses[%0d]: got %0d press / %0d release expected 1 / 1", rep, press_cnt, rel_cnt);
      end
      vectors++;
      if (led_bad !== 0) begin
        miscompares++;
        $display("[TB] FAIL led0_timing[%0d]: got %0d wrong LED cycles expected 0", rep, led_bad);
      end
      vectors++;
      if (sw_bus.o_LED[0] !== led_final) begin
        miscompares++;
        $display("[TB] FAIL led0_final[%0d]: got %b expected %b", rep, sw_bus.o_LED[0], led_final);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n, overlap;
    int order [4];
    int when  [4];
    n = 0; overlap = 0;
    sw_bus.i_Switch = 4'b0000;
    repeat (SETTLE) tick();
    vectors++;
    if (sw_bus.o_Switch !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL simul_clear: got %b expected 0000", sw_bus.o_Switch);
    end
    // Driving at the start of switch 3's visit lets the new levels reach the
    // synchronizer output just after switch 3 samples, so switch 0 sees them
    // first.
    wait_idx(2'd2);
    wait_idx(2'd3);
    sw_bus.i_Switch = 4'b1111;
    for (int k = 1; k <= SETTLE; k++) begin
      tick();
      if ($countones(sw_bus.o_Press | sw_bus.o_Release) > 1) overlap++;
      for (int b = 0; b < NUM_SW; b++) begin
        if (sw_bus.o_Press[b] && n < 4) begin
          order[n] = b;
          when[n]  = k;
          n++;
        end
      end
    end
    vectors++;
    if (n !== 4 || overlap !== 0) begin
      miscompares++;
      $display("[TB] FAIL simul_count: got %0d presses / %0d overlaps expected 4 / 0", n, overlap);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        vectors++;
        if (order[i] !== i) begin
          miscompares++;
          $display("[TB] FAIL simul_order[%0d]: got switch %0d expected %0d", i, order[i], i);
        end
        if (i > 0) begin
          vectors++;
          if (when[i] - when[i-1] !== VISIT_CYCLES) begin
            miscompares++;
            $display("[TB] FAIL simul_gap[%0d]: got %0d cycles expected %0d", i, when[i] - when[i-1], VISIT_CYCLES);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int press_at, press_cnt, other_cnt;
    press_at = -1; press_cnt = 0; other_cnt = 0;
    sw_bus.i_Switch = 4'b0000;
    repeat (SETTLE) tick();
    // Switch 3's next visit is its first qualifying one; 21 cycles later its
    // second visit is in COMPARE.
    wait_idx(2'd1);
    wait_idx(2'd2);
    sw_bus.i_Switch[3] = 1'b1;
    repeat (21) tick();
    vectors++;
    if (sw_bus.o_Scan_Idx !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL midcount_idx: got %0d expected 3", sw_bus.o_Scan_Idx);
    end
    tick();
    rst_n = 1'b0;
    repeat (4) tick();
    vectors++;
    if ((sw_bus.o_Press | sw_bus.o_Release | sw_bus.o_Switch) !== 4'b0000 || sw_bus.o_Scan_Idx !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL midcount_reset: got switch %b press %b release %b idx %0d expected all 0",
               sw_bus.o_Switch, sw_bus.o_Press, sw_bus.o_Release, sw_bus.o_Scan_Idx);
    end
    rst_n = 1'b1;
    // Sync settles by cycle 2; switch 3 is sampled at cycles 13, 29, 45 and
    // commits on the third visit, pulsing after cycle 47.
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (sw_bus.o_Press[3]) begin
        press_cnt++;
        if (press_at < 0) press_at = k;
      end
      if (((sw_bus.o_Press & 4'b0111) | sw_bus.o_Release) != 4'b0000) other_cnt++;
    end
    vectors++;
    if (press_at !== 47 || press_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL midcount_requal: got press at %0d (%0d pulses) expected at 47 (1 pulse)", press_at, press_cnt);
    end
    vectors++;
    if (other_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL midcount_others: got %0d stray pulse cycles expected 0", other_cnt);
    end
  endtask

  initial begin
    sw_bus.i_Switch = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_led();
    test_simultaneous();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
